etap_dr_cell: RTL and testbench
===============================

Name: etap_dr_cell

Overview:
- Generic EJTAG TAP data register: the register-side endpoint that sits behind the DR select mux.
- Consumes the per-register shift_dr/clk_dr/update_dr strobes routed by the mux and returns its serial bit on s_data_out.
- Performs capture, LSB-first shift and update.
- Presents each updated word to the system side through a valid/ready handshake, with overflow and length-error detection.
- One instance per ETAP register (ADDRESS, DATA, CONTROL, ...).

Parameters:
- W, 32, register width in bits (legal range 1..64).
- RESET_VAL, '0, reset value of the shift and update registers.
- STRICT, 1, when 1 an update is applied only if exactly W shifts occurred since the last capture.

Ports:
- tck  in  1  TAP clock; all state changes on its rising edge.
- trst_n  in  1  asynchronous active-low reset.
- s_data_in  in  1  serial input (TDI).
- shift_dr  in  1  shift select from the DR mux: 1 = shift, 0 = capture.
- clk_dr  in  1  capture/shift enable strobe from the DR mux (sampled; not used as a clock).
- update_dr  in  1  update strobe from the DR mux.
- s_data_out  out  1  serial output to the DR mux, equal to shift_reg[0].
- cap_data  in  W  parallel value loaded on capture.
- upd_data  out  W  last accepted update word.
- upd_valid  out  1  upd_data pending consumption.
- upd_ready  in  1  system side accepts upd_data.
- upd_ovf  out  1  sticky: an update overwrote an unconsumed word.
- ovf_clr  in  1  clears upd_ovf.
- len_err  out  1  sticky: an update was rejected because of a wrong shift count (STRICT=1 only).

Behaviour:
- Reset (trst_n=0, asynchronous):
  - shift_reg=RESET_VAL, upd_data=RESET_VAL.
  - upd_valid=0, upd_ovf=0, len_err=0, shift_cnt=0.
  - s_data_out=RESET_VAL[0].
- Capture, when clk_dr=1 & shift_dr=0: shift_reg<=cap_data, shift_cnt<=0, len_err<=0.
- Shift, when clk_dr=1 & shift_dr=1:
  - shift_reg<={s_data_in, shift_reg[W-1:1]}.
  - shift_cnt<=min(shift_cnt+1, W+1); counter width is clog2(W+2).
- s_data_out is purely registered (shift_reg[0]). New bit is visible the cycle after each shift edge; zero combinational path from inputs.
- Update, when update_dr=1: evaluated against the pre-edge shift_reg and shift_cnt.
  - STRICT=1 and shift_cnt!=W: update rejected, len_err<=1, upd_data/upd_valid unchanged.
  - Otherwise: upd_data<=shift_reg, upd_valid<=1.
  - If upd_valid=1 and upd_ready=0 on the same edge: upd_ovf<=1.
- Handshake FSM, 2 states:
  - IDLE (upd_valid=0) -> PEND on an accepted update.
  - PEND -> IDLE on an edge with upd_ready=1 and no accepted update.
  - PEND + upd_ready=1 + accepted update on the same edge: the old word is consumed, the new word becomes pending; stay PEND, no overflow.
  - upd_ready while IDLE is ignored.
- update_dr together with clk_dr on one edge: the TAP never does this, but behaviour is defined. Update uses the pre-edge shift_reg; the capture/shift action is also applied.
- ovf_clr=1: upd_ovf<=0. If a new overflow happens on the same edge, set wins.
- Zero shifts between capture and update: with STRICT=1 this is a len_err. With STRICT=0, cap_data is written back as upd_data.
- Shifting more than W bits: shift_cnt saturates at W+1 and the bits pass through. With STRICT=1 this is a len_err.
- Latency: capture->s_data_out valid is 1 tck; update_dr edge->upd_valid is 1 tck.

Decomposition:
- Shared package etap_pkg holds ETAP_DR_W default, the SEL_* register index constants (consistent with etap_constants.vh) and the typedef enum {HS_IDLE, HS_PEND} etap_hs_t.
- One natural sub-module, etap_upd_hs: holds the valid/ready/overflow logic, isolated so other ETAP registers can reuse it.

Test Plan:
- Reset/capture/shift: reset, cap_data=32'hA5A5_0F0F, capture, 32 shifts with s_data_in=0 -> s_data_out sequence 1,1,1,1,0,0,0,0,... (LSB first); 33rd sample is 0.
- Full-length update: shift in 32'hDEAD_BEEF LSB first, update -> upd_data=32'hDEAD_BEEF, upd_valid=1 next cycle; upd_ready one cycle -> upd_valid=0.
- Overflow: update 32'h1 with upd_ready=0, then update 32'h2 -> upd_data=32'h2, upd_valid=1, upd_ovf=1; ovf_clr -> upd_ovf=0.
- Simultaneous ack and update: pending 32'h1, upd_ready=1 on the same edge as update 32'h2 -> upd_data=32'h2, upd_valid=1, upd_ovf=0.
- Length error (STRICT=1): capture, 31 shifts, update -> len_err=1, upd_valid unchanged, upd_data unchanged; next capture -> len_err=0.
- Async reset mid-shift: assert trst_n=0 after 10 shifts while PEND -> all outputs return to reset values immediately, without a tck edge.

Source files
------------

// File: rtl/etap_pkg.sv
// Shared ETAP definitions: default DR width, DR select indices and the
// update handshake state type used by every ETAP data register.
package etap_pkg;

    // Default width of an ETAP data register.
    localparam int ETAP_DR_W = 32;

    // DR select indices (EJTAG instruction codes that route the DR mux).
    localparam logic [4:0] SEL_IDCODE      = 5'h01;
    localparam logic [4:0] SEL_IMPCODE     = 5'h03;
    localparam logic [4:0] SEL_ADDRESS     = 5'h08;
    localparam logic [4:0] SEL_DATA        = 5'h09;
    localparam logic [4:0] SEL_CONTROL     = 5'h0A;
    localparam logic [4:0] SEL_ALL         = 5'h0B;
    localparam logic [4:0] SEL_EJTAGBOOT   = 5'h0C;
    localparam logic [4:0] SEL_NORMALBOOT  = 5'h0D;
    localparam logic [4:0] SEL_FASTDATA    = 5'h0E;
    localparam logic [4:0] SEL_BYPASS      = 5'h1F;

    // Update handshake: nothing pending / a word waits for the system side.
    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_PEND = 1'b1
    } etap_hs_t;

    // Shift counter width: it must hold 0..W+1 (W+1 marks "too many shifts").
    function automatic int etap_cnt_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/etap_upd_hs.sv
// Valid/ready handshake for an ETAP update word, with sticky overflow.
// Kept separate so any ETAP register can reuse the same consumption logic.
module etap_upd_hs
    import etap_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic upd_accept,
    input  logic upd_ready,
    input  logic ovf_clr,
    output logic upd_valid,
    output logic upd_ovf
);

    etap_hs_t state_reg;
    etap_hs_t state_next;
    logic     ovf_reg;
    logic     ovf_next;

    // State and sticky overflow flag registers.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_reg <= HS_IDLE;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next state: a new word always ends up pending; an ack without a new
    // word drains. An overwrite without an ack on the same edge is an
    // overflow, and a fresh overflow beats a simultaneous clear.
    always_comb begin
        state_next = state_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            HS_IDLE: begin
                if (upd_accept) begin
                    state_next = HS_PEND;
                end
            end
            HS_PEND: begin
                if (!upd_accept && upd_ready) begin
                    state_next = HS_IDLE;
                end
            end
        endcase
        if (ovf_clr) begin
            ovf_next = 1'b0;
        end
        if ((state_reg == HS_PEND) && upd_accept && !upd_ready) begin
            ovf_next = 1'b1;
        end
    end

    assign upd_valid = (state_reg == HS_PEND);
    assign upd_ovf   = ovf_reg;

endmodule

// File: rtl/etap_dr_cell.sv
// Generic ETAP data register cell: capture, LSB-first shift and update,
// with the updated word handed to the system side via valid/ready.
module etap_dr_cell
    import etap_pkg::*;
#(
    parameter int           W         = ETAP_DR_W,
    parameter logic [W-1:0] RESET_VAL = '0,
    parameter int           STRICT    = 1
) (
    input  logic         tck,
    input  logic         trst_n,
    input  logic         s_data_in,
    input  logic         shift_dr,
    input  logic         clk_dr,
    input  logic         update_dr,
    output logic         s_data_out,
    input  logic [W-1:0] cap_data,
    output logic [W-1:0] upd_data,
    output logic         upd_valid,
    input  logic         upd_ready,
    output logic         upd_ovf,
    input  logic         ovf_clr,
    output logic         len_err
);

    localparam int            CW       = etap_cnt_w(W);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

    logic [W-1:0]  shift_reg;
    logic [W-1:0]  shifted;
    logic [CW-1:0] shift_cnt_reg;
    logic [W-1:0]  upd_data_reg;
    logic          len_err_reg;
    logic          len_ok;
    logic          upd_accept;
    logic          upd_reject;

    // Right-shift network: TDI enters at the MSB, each bit moves one toward
    // the LSB. Written per bit so a 1-bit register needs no special case.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shift
            if (gi == W - 1) begin : g_msb
                assign shifted[gi] = s_data_in;
            end else begin : g_mid
                assign shifted[gi] = shift_reg[gi + 1];
            end
        end
    endgenerate

    // An update is judged on the pre-edge count; in lenient mode any count goes.
    assign len_ok     = (STRICT == 0) || (shift_cnt_reg == CNT_FULL);
    assign upd_accept = update_dr & len_ok;
    assign upd_reject = update_dr & ~len_ok;

    // Capture/shift datapath with a saturating shift counter.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            shift_reg     <= RESET_VAL;
            shift_cnt_reg <= '0;
        end else if (clk_dr) begin
            if (shift_dr) begin
                shift_reg <= shifted;
                if (shift_cnt_reg != CNT_SAT) begin
                    shift_cnt_reg <= shift_cnt_reg + CW'(1);
                end
            end else begin
                shift_reg     <= cap_data;
                shift_cnt_reg <= '0;
            end
        end
    end

    // Length error: set by a rejected update, cleared by the next capture.
    // A rejection on the same edge as a capture still reports the error.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            len_err_reg <= 1'b0;
        end else if (upd_reject) begin
            len_err_reg <= 1'b1;
        end else if (clk_dr && !shift_dr) begin
            len_err_reg <= 1'b0;
        end
    end

    // Update word latch: takes the pre-edge shift register on acceptance.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            upd_data_reg <= RESET_VAL;
        end else if (upd_accept) begin
            upd_data_reg <= shift_reg;
        end
    end

    etap_upd_hs u_hs (
        .tck        (tck),
        .trst_n     (trst_n),
        .upd_accept (upd_accept),
        .upd_ready  (upd_ready),
        .ovf_clr    (ovf_clr),
        .upd_valid  (upd_valid),
        .upd_ovf    (upd_ovf)
    );

    assign s_data_out = shift_reg[0];
    assign upd_data   = upd_data_reg;
    assign len_err    = len_err_reg;

endmodule

// File: tb/tb_etap_dr_cell.sv
// Directed bench for etap_dr_cell (W=32, STRICT=1, RESET_VAL=0).
module tb_etap_dr_cell;

    logic        tck;
    logic        trst_n;
    logic        s_data_in;
    logic        shift_dr;
    logic        clk_dr;
    logic        update_dr;
    logic        s_data_out;
    logic [31:0] cap_data;
    logic [31:0] upd_data;
    logic        upd_valid;
    logic        upd_ready;
    logic        upd_ovf;
    logic        ovf_clr;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    etap_dr_cell #(.W(32), .RESET_VAL(32'h0), .STRICT(1)) dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .s_data_in  (s_data_in),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .s_data_out (s_data_out),
        .cap_data   (cap_data),
        .upd_data   (upd_data),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_ovf    (upd_ovf),
        .ovf_clr    (ovf_clr),
        .len_err    (len_err)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_capture(input logic [31:0] val);
        cap_data = val;
        clk_dr   = 1'b1;
        shift_dr = 1'b0;
        tick();
        clk_dr   = 1'b0;
    endtask

    task automatic do_shift(input logic b);
        s_data_in = b;
        clk_dr    = 1'b1;
        shift_dr  = 1'b1;
        tick();
        clk_dr    = 1'b0;
        shift_dr  = 1'b0;
    endtask

    task automatic do_update();
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        $display("update: upd_data=%h valid=%b ovf=%b len_err=%b", upd_data, upd_valid, upd_ovf, len_err);
    endtask

    task automatic load_word(input logic [31:0] w);
        do_capture(32'h0);
        for (int i = 0; i < 32; i++) begin
            do_shift(w[i]);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (s_data_out !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b want 0", s_data_out); end
        checks++; if (upd_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", upd_data); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", upd_valid); end
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", upd_ovf); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b want 0", len_err); end
        @(posedge tck);
        #1;
        trst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_capture_shift();
        logic [31:0] cap;
        logic        exp_bit;
        cap = 32'hA5A5_0F0F;
        do_capture(cap);
        for (int k = 0; k <= 32; k++) begin
            exp_bit = (k < 32) ? cap[k] : 1'b0;
            checks++;
            if (s_data_out !== exp_bit) begin
                errors++;
                $display("FAIL shift_sdo[%0d] got %b want %b", k, s_data_out, exp_bit);
            end
            if (k < 32) do_shift(1'b0);
        end
        $display("capture/shift: 33 serial samples compared");
    endtask

    task automatic test_full_update();
        load_word(32'hDEAD_BEEF);
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL full_pre_valid got %b want 0", upd_valid); end
        do_update();
        checks++; if (upd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_data got %h want deadbeef", upd_data); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", upd_valid); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL full_len_err got %b want 0", len_err); end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL full_ack_valid got %b want 0", upd_valid); end
        checks++; if (upd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_ack_data got %h want deadbeef", upd_data); end
    endtask

    task automatic test_overflow();
        load_word(32'h1);
        do_update();
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first got %b want 0", upd_ovf); end
        load_word(32'h2);
        do_update();
        checks++; if (upd_data !== 32'h2) begin errors++; $display("FAIL ovf_data got %h want 00000002", upd_data); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", upd_valid); end
        checks++; if (upd_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", upd_ovf); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", upd_ovf); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL ovf_clr_valid got %b want 1", upd_valid); end
        // New overflow on the same edge as a clear: set wins.
        load_word(32'h3);
        ovf_clr = 1'b1;
        do_update();
        ovf_clr = 1'b0;
        checks++; if (upd_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", upd_ovf); end
        checks++; if (upd_data !== 32'h3) begin errors++; $display("FAIL ovf_set_wins_data got %h want 00000003", upd_data); end
        ovf_clr   = 1'b1;
        upd_ready = 1'b1;
        tick();
        ovf_clr   = 1'b0;
        upd_ready = 1'b0;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_valid got %b want 0", upd_valid); end
    endtask

    task automatic test_ack_and_update();
        load_word(32'h1);
        do_update();
        load_word(32'h2);
        upd_ready = 1'b1;
        do_update();
        upd_ready = 1'b0;
        checks++; if (upd_data !== 32'h2) begin errors++; $display("FAIL ackupd_data got %h want 00000002", upd_data); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL ackupd_valid got %b want 1", upd_valid); end
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL ackupd_ovf got %b want 0", upd_ovf); end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL ackupd_drain got %b want 0", upd_valid); end
    endtask

    task automatic test_len_err();
        load_word(32'h7);
        do_update();
        // 31 shifts: rejected.
        do_capture(32'h0);
        for (int i = 0; i < 31; i++) do_shift(1'b1);
        do_update();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len31_err got %b want 1", len_err); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL len31_valid got %b want 1", upd_valid); end
        checks++; if (upd_data !== 32'h7) begin errors++; $display("FAIL len31_data got %h want 00000007", upd_data); end
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL len31_ovf got %b want 0", upd_ovf); end
        do_capture(32'h0);
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_capture_clr got %b want 0", len_err); end
        // Zero shifts: rejected.
        do_update();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len0_err got %b want 1", len_err); end
        checks++; if (upd_data !== 32'h7) begin errors++; $display("FAIL len0_data got %h want 00000007", upd_data); end
        // 33 shifts: counter saturates, still rejected; bits pass through.
        do_capture(32'h0);
        for (int i = 0; i < 33; i++) do_shift(1'b1);
        checks++; if (s_data_out !== 1'b1) begin errors++; $display("FAIL len33_sdo got %b want 1", s_data_out); end
        do_update();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len33_err got %b want 1", len_err); end
        checks++; if (upd_data !== 32'h7) begin errors++; $display("FAIL len33_data got %h want 00000007", upd_data); end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL len_drain got %b want 0", upd_valid); end
    endtask

    task automatic test_async_reset();
        load_word(32'h5);
        do_update();
        load_word(32'h6);
        do_update();
        do_capture(32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) do_shift(1'b1);
        do_update();
        checks++; if (s_data_out !== 1'b1) begin errors++; $display("FAIL ar_pre_sdo got %b want 1", s_data_out); end
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", upd_valid); end
        checks++; if (upd_ovf !== 1'b1) begin errors++; $display("FAIL ar_pre_ovf got %b want 1", upd_ovf); end
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL ar_pre_len_err got %b want 1", len_err); end
        #2;
        trst_n = 1'b0;
        #1;
        checks++; if (s_data_out !== 1'b0) begin errors++; $display("FAIL ar_sdo got %b want 0", s_data_out); end
        checks++; if (upd_data !== 32'h0) begin errors++; $display("FAIL ar_data got %h want 00000000", upd_data); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", upd_valid); end
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL ar_ovf got %b want 0", upd_ovf); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL ar_len_err got %b want 0", len_err); end
        tick();
        trst_n = 1'b1;
        $display("async reset applied mid-cycle");
    endtask

    initial begin
        trst_n    = 1'b0;
        s_data_in = 1'b0;
        shift_dr  = 1'b0;
        clk_dr    = 1'b0;
        update_dr = 1'b0;
        cap_data  = 32'h0;
        upd_ready = 1'b0;
        ovf_clr   = 1'b0;

        test_reset();
        test_capture_shift();
        test_full_update();
        test_overflow();
        test_ack_and_update();
        test_len_err();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
